mod3_seq_checker: RTL and testbench

//   Receive end of the 3-phase state sequence (00->01->10->00...) driven by the sequence generator.
//   - Samples the 2-bit phase bus and acquires lock on the sequence.
//   - Flags each out-of-order or illegal phase and counts errors and completed periods.
//   - Sits on the consumer side of the generator; its status feeds debug registers.

---
 rtl/mod3_seq_checker_pkg.sv | 10 +
 rtl/mod3_seq_checker_if.sv | 15 +
 rtl/mod3_seq_checker_sat_counter.sv | 18 +
 rtl/mod3_seq_checker.sv | 95 +++++++++
 tb/tb_mod3_seq_checker.sv | 109 ++++++++++
 5 files changed

// File: rtl/mod3_seq_checker_pkg.sv
// mod3_seq_checker_pkg: phase constants, checker state encoding and phase successor shared with the generator
package mod3_seq_checker_pkg;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_e;
  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == S0) ? S1 : (p == S1) ? S2 : S0;
  endfunction
endpackage

// File: rtl/mod3_seq_checker_if.sv
// mod3_seq_checker_if: phase bus from the generator plus checker status toward debug registers
interface mod3_seq_checker_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic [1:0]       in_state;
  logic             clr_counts;
  logic             locked;
  logic             err_pulse;
  logic [1:0]       expected;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] period_count;
  modport master (output in_valid, in_state, clr_counts,
                  input locked, err_pulse, expected, err_count, period_count);
  modport slave (input in_valid, in_state, clr_counts,
                 output locked, err_pulse, expected, err_count, period_count);
endinterface

// File: rtl/mod3_seq_checker_sat_counter.sv
// sat_counter: event counter with synchronous clear priority; saturates when SAT=1, wraps when SAT=0
module sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : (inc_i && !(SAT && &count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/mod3_seq_checker.sv
// mod3_seq_checker: acquires lock on the 00->01->10 phase sequence and flags/counts out-of-order phases
module mod3_seq_checker
  import mod3_seq_checker_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  mod3_seq_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  state_e        state_q, state_d;
  logic [1:0]    expected_q, expected_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic          err_q, err_d;
  logic          legal, hit, period_inc;
  logic [1:0]    nxt;
  assign legal = bus.in_state != 2'b11;
  assign hit   = bus.in_state == expected_q;
  assign nxt   = next_phase(bus.in_state);
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: if (legal) begin
          expected_d = nxt;
          match_d    = MW'(1);
          miss_d     = '0;
          state_d    = (LOCK_N == 1) ? LOCKED : VERIFY;
        end
        VERIFY: if (!legal) begin
          state_d = HUNT;
          match_d = '0;
        end else if (hit) begin
          expected_d = nxt;
          match_d    = match_q + 1'b1;
          if (match_d == MW'(LOCK_N)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end else begin
          expected_d = nxt;
          match_d    = MW'(1);
        end
        LOCKED: if (hit) begin
          expected_d = nxt;
          miss_d     = '0;
        end else begin
          // flywheel: keep advancing the expected phase through the miss
          err_d      = 1'b1;
          expected_d = next_phase(expected_q);
          miss_d     = miss_q + 1'b1;
          if (miss_d == LW'(LOSS_N)) begin
            state_d = HUNT;
            match_d = '0;
            miss_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= HUNT;
      expected_q <= S0;
      match_q    <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
    end
  assign period_inc = bus.in_valid && state_q == LOCKED && hit && bus.in_state == S2;
  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err (
    .clk(clk), .reset(reset), .inc_i(err_d), .clr_i(bus.clr_counts), .count_o(bus.err_count)
  );
  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_period (
    .clk(clk), .reset(reset), .inc_i(period_inc), .clr_i(bus.clr_counts), .count_o(bus.period_count)
  );
  assign bus.locked    = state_q == LOCKED;
  assign bus.err_pulse = err_q;
  assign bus.expected  = expected_q;
endmodule

// File: tb/tb_mod3_seq_checker.sv
// tb_mod3_seq_checker: directed phase sequences with hand-computed expectations on a 16-bit and a 2-bit counter instance
module tb_mod3_seq_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mod3_seq_checker_if #(.CNT_W(16)) a_if ();
  mod3_seq_checker_if #(.CNT_W(2))  b_if ();
  mod3_seq_checker #(.LOCK_N(3), .LOSS_N(2), .CNT_W(16)) u_a (.clk(clk), .reset(rst_n), .bus(a_if.slave));
  mod3_seq_checker #(.LOCK_N(3), .LOSS_N(2), .CNT_W(2))  u_b (.clk(clk), .reset(rst_n), .bus(b_if.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_a(input logic [1:0] s);
    a_if.in_valid = 1'b1;
    a_if.in_state = s;
    tick();
    a_if.in_valid = 1'b0;
  endtask
  task automatic send_b(input logic [1:0] s, input logic clr);
    b_if.in_valid   = 1'b1;
    b_if.in_state   = s;
    b_if.clr_counts = clr;
    tick();
    b_if.in_valid   = 1'b0;
    b_if.clr_counts = 1'b0;
  endtask
  task automatic stat_a(input string tag, input logic lk, input logic ep, input logic [1:0] ex,
                        input logic [15:0] ec, input logic [15:0] pc);
    chk({tag, ".locked"}, 32'(a_if.locked), 32'(lk));
    chk({tag, ".err_pulse"}, 32'(a_if.err_pulse), 32'(ep));
    chk({tag, ".expected"}, 32'(a_if.expected), 32'(ex));
    chk({tag, ".err_count"}, 32'(a_if.err_count), 32'(ec));
    chk({tag, ".period_count"}, 32'(a_if.period_count), 32'(pc));
  endtask
  initial begin
    a_if.in_valid = 1'b0; a_if.in_state = 2'b00; a_if.clr_counts = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_state = 2'b00; b_if.clr_counts = 1'b0;
    #12;
    stat_a("reset", 0, 0, 2'b00, 0, 0);
    rst_n = 1'b1;
    tick();
    // acquisition: lock one edge after the third in-order sample
    send_a(2'b00); stat_a("acq1", 0, 0, 2'b01, 0, 0);
    send_a(2'b01); stat_a("acq2", 0, 0, 2'b10, 0, 0);
    send_a(2'b10); stat_a("acq3", 1, 0, 2'b00, 0, 0);
    send_a(2'b00);
    send_a(2'b01);
    send_a(2'b10); stat_a("period1", 1, 0, 2'b00, 0, 1);
    // single injected error
    send_a(2'b00);
    send_a(2'b00); stat_a("inj", 1, 1, 2'b10, 1, 1);
    send_a(2'b10); stat_a("inj_after", 1, 0, 2'b00, 1, 2);
    send_a(2'b00);
    send_a(2'b01); stat_a("inj_clean", 1, 0, 2'b10, 1, 2);
    // clear with no valid sample, then two illegal samples drop lock
    a_if.clr_counts = 1'b1; tick(); a_if.clr_counts = 1'b0;
    stat_a("clr_idle", 1, 0, 2'b10, 0, 0);
    send_a(2'b11); stat_a("ill1", 1, 1, 2'b00, 1, 0);
    send_a(2'b11); stat_a("ill2", 0, 1, 2'b01, 2, 0);
    send_a(2'b00); stat_a("rel1", 0, 0, 2'b01, 2, 0);
    send_a(2'b01); stat_a("rel2", 0, 0, 2'b10, 2, 0);
    send_a(2'b10); stat_a("rel3", 1, 0, 2'b00, 2, 0);
    // reseed while verifying
    rst_n = 1'b0; #2; rst_n = 1'b1; tick();
    stat_a("rst2", 0, 0, 2'b00, 0, 0);
    send_a(2'b00);
    send_a(2'b01);
    send_a(2'b00); stat_a("reseed", 0, 0, 2'b01, 0, 0);
    send_a(2'b01); stat_a("reseed2", 0, 0, 2'b10, 0, 0);
    send_a(2'b10); stat_a("reseed_lock", 1, 0, 2'b00, 0, 0);
    // idle freeze while locked
    send_a(2'b01); stat_a("pre_idle", 1, 1, 2'b01, 1, 0);
    for (int i = 0; i < 10; i++) tick();
    stat_a("idle", 1, 0, 2'b01, 1, 0);
    #3 rst_n = 1'b0;
    #1 stat_a("async_rst", 0, 0, 2'b00, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // 2-bit counter instance: saturation and clear-over-increment
    send_b(2'b00, 0); send_b(2'b01, 0); send_b(2'b10, 0);
    chk("b.locked", 32'(b_if.locked), 1);
    send_b(2'b11, 0); chk("b.err1", 32'(b_if.err_count), 1);
    send_b(2'b01, 0);
    send_b(2'b11, 0); chk("b.err2", 32'(b_if.err_count), 2);
    send_b(2'b00, 0);
    send_b(2'b11, 0); chk("b.err3", 32'(b_if.err_count), 3);
    send_b(2'b10, 0); chk("b.period", 32'(b_if.period_count), 1);
    send_b(2'b11, 0); chk("b.sat", 32'(b_if.err_count), 3);
    chk("b.sat_locked", 32'(b_if.locked), 1);
    chk("b.sat_exp", 32'(b_if.expected), 2'b01);
    send_b(2'b01, 0);
    send_b(2'b11, 1);
    chk("b.clr_err", 32'(b_if.err_count), 0);
    chk("b.clr_pulse", 32'(b_if.err_pulse), 1);
    chk("b.clr_period", 32'(b_if.period_count), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
